// File: rtl/median_3x3_frame_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the 3x3 median frame controller.
package median_3x3_frame_ctrl_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2_f(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  // Median results expected per frame: one per interior 3x3 window.
  function automatic int n_outputs(input int rows, input int cols);
    return (rows - 2) * (cols - 2);
  endfunction

endpackage

// File: rtl/median_3x3_frame_ctrl_pos.sv
// Raster position tracker: row/column of the pixel about to be accepted,
// with a window flag once WIN_MIN rows and columns are buffered.
module raster_pos_counter
  import median_3x3_frame_ctrl_pkg::*;
#(
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int WIN_MIN = 2,
  parameter int ROW_W   = clog2_f(ROWS),
  parameter int COL_W   = clog2_f(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             at_window_o,
  output logic             at_last_o
);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  // Advance in raster order; the last pixel wraps back to (0,0).
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clr_i) begin
      r_row <= '0;
      r_col <= '0;
    end else if (adv_i) begin
      if (r_col == COL_W'(COLS - 1)) begin
        r_col <= '0;
        r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign row_o       = r_row;
  assign col_o       = r_col;
  assign at_window_o = (r_row >= ROW_W'(WIN_MIN)) && (r_col >= COL_W'(WIN_MIN));
  assign at_last_o   = (r_row == ROW_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1));

endmodule

// File: rtl/median_3x3_frame_ctrl.sv
// Frame sequencer for the 3x3 median path: accepts a raster stream, issues one
// window strobe per interior pixel, and counts median results to close the frame.
module median_3x3_frame_ctrl
  import median_3x3_frame_ctrl_pkg::*;
#(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int DRAIN_MAX = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     pix_valid_i,
  output logic                     pix_ready_o,
  output logic                     win_valid_o,
  input  logic                     med_valid_i,
  output logic [clog2_f(ROWS)-1:0] row_o,
  output logic [clog2_f(COLS)-1:0] col_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     err_o
);

  localparam int ROW_W = clog2_f(ROWS);
  localparam int COL_W = clog2_f(COLS);
  localparam int N_OUT = n_outputs(ROWS, COLS);
  localparam int OUT_W = clog2_f(N_OUT + 1);
  localparam int DRN_W = clog2_f(DRAIN_MAX + 1);

  state_t           r_state;
  state_t           w_next;
  logic [ROW_W-1:0] w_pos_row;
  logic [COL_W-1:0] w_pos_col;
  logic             w_at_window;
  logic             w_at_last;
  logic             w_start;
  logic             w_accept;
  logic             w_med_cnt;
  logic             w_out_full;
  logic             w_out_done;
  logic             w_drain_exp;
  logic [OUT_W-1:0] r_out_cnt;
  logic [DRN_W-1:0] r_drain_cnt;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_err;
  logic             r_win_valid;
  logic             r_pix_ready;
  logic             r_busy;
  logic             r_frame_done;

  raster_pos_counter #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .WIN_MIN (2),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (w_start),
    .adv_i       (w_accept),
    .row_o       (w_pos_row),
    .col_o       (w_pos_col),
    .at_window_o (w_at_window),
    .at_last_o   (w_at_last)
  );

  assign w_start     = start_i && (r_state == ST_IDLE);
  assign w_accept    = pix_valid_i && (r_state == ST_RUN);
  assign w_med_cnt   = med_valid_i && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_out_full  = (r_out_cnt == OUT_W'(N_OUT));
  // The Nth result closes the frame in the cycle it arrives.
  assign w_out_done  = w_out_full || (w_med_cnt && (r_out_cnt == OUT_W'(N_OUT - 1)));
  assign w_drain_exp = (r_drain_cnt == DRN_W'(DRAIN_MAX - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_next = ST_RUN;
      ST_RUN:   if (w_accept && w_at_last) w_next = ST_DRAIN;
      ST_DRAIN: if (w_out_done || w_drain_exp) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Position outputs, result/drain counters and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_out_cnt   <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else if (w_start) begin
      r_row       <= '0;
      r_col       <= '0;
      r_out_cnt   <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_row <= w_pos_row;
        r_col <= w_pos_col;
      end
      if (w_med_cnt) begin
        if (w_out_full) r_err     <= 1'b1;
        else            r_out_cnt <= r_out_cnt + OUT_W'(1);
      end
      if (r_state == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + DRN_W'(1);
        if (w_drain_exp && !w_out_done) r_err <= 1'b1;
      end
    end
  end

  // Registered status outputs decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_valid  <= 1'b0;
      r_pix_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= w_accept && w_at_window;
      r_pix_ready  <= (w_next == ST_RUN);
      r_busy       <= (w_next != ST_IDLE);
      r_frame_done <= (w_next == ST_DONE);
    end
  end

  assign pix_ready_o  = r_pix_ready;
  assign win_valid_o  = r_win_valid;
  assign row_o        = r_row;
  assign col_o        = r_col;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_median_3x3_frame_ctrl.sv
// Directed bench for median_3x3_frame_ctrl with a latency-4 filter model.
module tb_median_3x3_frame_ctrl;

  localparam int ROWS      = 5;
  localparam int COLS      = 5;
  localparam int DRAIN_MAX = 64;
  localparam int N_WIN     = (ROWS - 2) * (COLS - 2);

  logic clk = 1'b0;
  logic rst;
  logic start_i;
  logic pix_valid_i;
  logic pix_ready_o;
  logic win_valid_o;
  logic med_valid_i;
  logic [$clog2(ROWS)-1:0] row_o;
  logic [$clog2(COLS)-1:0] col_o;
  logic busy_o;
  logic frame_done_o;
  logic err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Filter model controls (written by the main sequence only).
  logic model_en = 1'b1;
  logic drop_en  = 1'b0;
  int   drop_at  = 0;
  logic inj_med  = 1'b0;
  // Filter model state (written by the model process only).
  logic [3:0] m_pipe    = '0;
  logic       model_med = 1'b0;
  int         m_results = 0;

  assign med_valid_i = model_med | inj_med;

  typedef struct {
    logic valid;
    logic start;
    int   exp_row;
    int   exp_col;
    logic exp_win;
  } vec_t;

  vec_t vecs[$];

  median_3x3_frame_ctrl #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .DRAIN_MAX (DRAIN_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .win_valid_o  (win_valid_o),
    .med_valid_i  (med_valid_i),
    .row_o        (row_o),
    .col_o        (col_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Filter model: each window strobe returns a median result four edges later.
  always @(posedge clk) begin
    #1;
    m_pipe    = {m_pipe[2:0], win_valid_o};
    model_med = 1'b0;
    if (m_pipe[3] && model_en) begin
      m_results++;
      if (!(drop_en && m_results == drop_at)) model_med = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, pix_ready_o, 0);
    check({tag, "_win"},   win_valid_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_done"},  frame_done_o, 0);
    check({tag, "_err"},   err_o, 0);
    check({tag, "_row"},   row_o, 0);
    check({tag, "_col"},   col_o, 0);
  endtask

  // Build one stimulus table: pixel k lands at (k/COLS, k%COLS) and opens a
  // window when both indices are at least 2; idle cycles hold the last position.
  task automatic build_vecs(input logic [31:0] pattern, input int n_pix, input int start_at);
    vec_t v;
    int   k;
    int   i;
    int   last_r;
    int   last_c;
    vecs.delete();
    k = 0; i = 0; last_r = 0; last_c = 0;
    while (k < n_pix && i < 1000) begin
      v.start = (i == start_at);
      v.valid = v.start ? 1'b0 : pattern[i % 32];
      if (v.valid) begin
        last_r = k / COLS;
        last_c = k % COLS;
        k++;
      end
      v.exp_row = last_r;
      v.exp_col = last_c;
      v.exp_win = v.valid && (last_r >= 2) && (last_c >= 2);
      vecs.push_back(v);
      i++;
    end
  endtask

  task automatic apply_vecs(input string tag, output int wins);
    wins = 0;
    foreach (vecs[i]) begin
      start_i     = vecs[i].start;
      pix_valid_i = vecs[i].valid;
      step();
      if (win_valid_o) wins++;
      check($sformatf("%s_win[%0d]", tag, i), win_valid_o, vecs[i].exp_win);
      check($sformatf("%s_row[%0d]", tag, i), row_o, vecs[i].exp_row);
      check($sformatf("%s_col[%0d]", tag, i), col_o, vecs[i].exp_col);
      if (vecs[i].start) begin
        check($sformatf("%s_start_run_busy[%0d]", tag, i), busy_o, 1);
        check($sformatf("%s_start_run_ready[%0d]", tag, i), pix_ready_o, 1);
      end
    end
    start_i     = 1'b0;
    pix_valid_i = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check({tag, "_start_ready"}, pix_ready_o, 1);
    check({tag, "_start_busy"},  busy_o, 1);
    check({tag, "_start_err"},   err_o, 0);
    check({tag, "_start_row"},   row_o, 0);
    check({tag, "_start_col"},   col_o, 0);
  endtask

  task automatic wait_frame_done(input int budget, output int cycles);
    cycles = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (frame_done_o) begin
        cycles = i + 1;
        break;
      end
    end
  endtask

  // Feed a 25-pixel frame, then check drain entry, completion latency
  // (cycles from the last accepted pixel to frame_done_o) and end status.
  task automatic run_frame(input string tag, input logic [31:0] pattern, input int start_at,
                           input bit drain_start, input int exp_done, input int exp_err);
    int wins;
    int cyc;
    int extra;
    build_vecs(pattern, ROWS * COLS, start_at);
    apply_vecs(tag, wins);
    check({tag, "_win_count"},   wins, N_WIN);
    check({tag, "_drain_ready"}, pix_ready_o, 0);
    check({tag, "_drain_busy"},  busy_o, 1);
    extra = 0;
    if (drain_start) begin
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check({tag, "_drain_start_ready"}, pix_ready_o, 0);
      check({tag, "_drain_start_busy"},  busy_o, 1);
      extra = 1;
    end
    wait_frame_done(200, cyc);
    check({tag, "_done_latency"}, (cyc < 0) ? cyc : cyc + extra, exp_done);
    check({tag, "_err_at_done"},  err_o, exp_err);
    step();
    check({tag, "_done_one_pulse"}, frame_done_o, 0);
    check({tag, "_busy_after"},     busy_o, 0);
    check({tag, "_err_sticky"},     err_o, exp_err);
  endtask

  initial begin
    rst         = 1'b0;
    start_i     = 1'b0;
    pix_valid_i = 1'b0;
    #2;
    check_reset_vals("reset");
    #20;
    rst = 1'b1;
    step();

    // Pixels offered in IDLE are ignored.
    pix_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle_ready[%0d]", i), pix_ready_o, 0);
      check($sformatf("idle_win[%0d]", i),   win_valid_o, 0);
      check($sformatf("idle_col[%0d]", i),   col_o, 0);
      check($sformatf("idle_busy[%0d]", i),  busy_o, 0);
    end
    pix_valid_i = 1'b0;

    // Nominal back-to-back frame.
    start_frame("nom");
    run_frame("nom", 32'hFFFF_FFFF, -1, 1'b0, 4, 0);

    // Gapped input with start pulses during RUN and DRAIN.
    start_frame("gap");
    run_frame("gap", 32'h9D6B_35A7, 10, 1'b1, 4, 0);

    // Drain timeout: the model drops this frame's last result.
    drop_at = m_results + N_WIN;
    drop_en = 1'b1;
    start_frame("tmo");
    run_frame("tmo", 32'hFFFF_FFFF, -1, 1'b0, DRAIN_MAX, 1);
    drop_en = 1'b0;

    // Overrun: ten injected results during RUN; count saturates at nine, so
    // the frame closes one cycle after the last pixel.
    model_en = 1'b0;
    start_frame("ovr");
    for (int i = 1; i <= 10; i++) begin
      inj_med = 1'b1;
      step();
      inj_med = 1'b0;
      check($sformatf("ovr_err[%0d]", i), err_o, (i >= 10) ? 1 : 0);
      step();
    end
    run_frame("ovr", 32'hFFFF_FFFF, -1, 1'b0, 1, 1);
    model_en = 1'b1;

    // Reset in the middle of a frame, then a clean frame.
    begin
      int wins;
      start_frame("rst");
      build_vecs(32'hFFFF_FFFF, 12, -1);
      apply_vecs("rst", wins);
      check("rst_pre_row", row_o, 2);
      check("rst_pre_col", col_o, 1);
      rst = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      #1;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("rst_idle_busy", busy_o, 0);
      check("rst_idle_err",  err_o, 0);
      start_frame("rst2");
      run_frame("rst2", 32'hFFFF_FFFF, -1, 1'b0, 4, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/median_3x3_frame_ctrl.md
# median_3x3_frame_ctrl

Frame-level sequencer for the 3x3 median path (window modulator plus median calculator). It accepts a raster pixel stream and tracks row and column position. It asserts the window-valid strobe that feeds the filter's `done_i` only when a full 3x3 window is in line buffers, then counts the filter's output strobes to signal frame completion. It sits between the pixel source and the median filter top and owns start, busy, done and error status for one frame at a time.

## Interface
- `ROWS`, default 5: frame height in pixels, at least 3.
- `COLS`, default 5: frame width in pixels, at least 3.
- `DRAIN_MAX`, default 64: maximum cycles allowed in DRAIN waiting for outstanding filter outputs.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start_i` input, 1 bit: one-cycle pulse that begins a frame; honoured only in IDLE.
- `pix_valid_i` input, 1 bit: source presents a pixel this cycle.
- `pix_ready_o` output, 1 bit: controller accepts pixels. A pixel is accepted when `pix_valid_i` and `pix_ready_o` are both 1.
- `win_valid_o` output, 1 bit: drives the filter `done_i`. High for one cycle per valid 3x3 window.
- `med_valid_i` input, 1 bit: the filter's `done_o`, one per median result.
- `row_o` output, clog2(ROWS) bits: row index of the last accepted pixel.
- `col_o` output, clog2(COLS) bits: column index of the last accepted pixel.
- `busy_o` output, 1 bit: high in every state except IDLE.
- `frame_done_o` output, 1 bit: one-cycle pulse when the frame is complete.
- `err_o` output, 1 bit: sticky error flag, cleared by `start_i` or by reset.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start_i` moves to RUN and clears the row, column, output and drain counters and `err_o`.
  - `pix_valid_i` is ignored in IDLE.
- RUN:
  - `pix_ready_o` = 1.
  - Each accepted pixel advances the column counter. When the column counter reaches COLS-1 it wraps to 0 and the row counter increments.
  - The accepted pixel at position (r,c) with r≥2 and c≥2 raises `win_valid_o` on the next cycle. Windows straddling the frame edge are never issued (no padding).
  - Acceptance of pixel (ROWS-1, COLS-1) moves to DRAIN.
- Expected output count: N = (ROWS-2)*(COLS-2). With the defaults, N = 9.
- Output counter:
  - Increments on each `med_valid_i` in RUN or DRAIN.
  - A `med_valid_i` arriving while the count is already N sets `err_o` (overrun). The count saturates at N.
- DRAIN:
  - `pix_ready_o` = 0.
  - When the output count equals N, move to DONE. This is checked in the same cycle, including the cycle in which the Nth `med_valid_i` arrives.
  - The drain counter increments each cycle. On reaching DRAIN_MAX, set `err_o` and move to DONE.
- DONE: `frame_done_o` = 1 for one cycle, then return to IDLE.
- `start_i` in any state other than IDLE is ignored and has no side effects.
- Arithmetic:
  - Counters are unsigned.
  - Row and column counters wrap only as described above and never exceed ROWS-1 or COLS-1.
  - The output counter is clog2(N+1) bits wide.

## Timing
- Reset values:
  - State = IDLE.
  - `pix_ready_o`, `win_valid_o`, `busy_o`, `frame_done_o`, `err_o` = 0.
  - `row_o`, `col_o` = 0.
- Reset mid-frame:
  - The block returns to IDLE immediately (asynchronous).
  - In-flight filter results that arrive after reset are ignored until the next `start_i`.
- Latency:
  - `start_i` at cycle t gives `pix_ready_o` = 1 at t+1.
  - An accepted pixel at cycle t gives `win_valid_o` at t+1.
  - `row_o` and `col_o` update at t+1.
- The last pixel accepted at cycle t gives DRAIN at t+1. `pix_ready_o` is 0 from t+1.
- The Nth `med_valid_i` at cycle t gives DONE at t+1 and `frame_done_o` at t+1.
- `busy_o` is 0 at t+2, the cycle after the `frame_done_o` pulse.
- All outputs are registered. There is no combinational path from any input to any output.
- `med_valid_i` arriving in RUN (pipeline overlap) is counted normally.

## Structure
- Shared package holds:
  - The state encoding typedef for IDLE, RUN, DRAIN, DONE.
  - A localparam function for N = (ROWS-2)*(COLS-2).
  - A clog2 helper.
- One natural sub-module: `raster_pos_counter`, holding the row and column counters with wrap logic and an `at_window` flag for r≥2 and c≥2. It is reusable by the 5x5 path, where the condition becomes r≥4 and c≥4.

## Test plan
- Nominal frame:
  - Stimulus: ROWS=COLS=5; `start_i`, then 25 pixels back to back; filter model returns results with latency 4.
  - Required: exactly 9 `win_valid_o` pulses, at the accepted pixels (2,2)…(4,4); one `frame_done_o`; `err_o` = 0.
- Gapped input:
  - Stimulus: `pix_valid_i` toggles randomly.
  - Required: the `win_valid_o` count is still 9; `row_o` and `col_o` match the accepted-pixel count; no window is issued on an idle cycle.
- Drain timeout:
  - Stimulus: the filter model drops its last result.
  - Required: after DRAIN_MAX cycles in DRAIN, `err_o` = 1 and `frame_done_o` pulses once; `busy_o` falls.
- Overrun:
  - Stimulus: the model emits 10 `med_valid_i` pulses.
  - Required: `err_o` sets on the 10th pulse; the output count stays at 9.
- Reset mid-frame:
  - Stimulus: `rst` asserted low after 12 pixels.
  - Required: all outputs are at their reset values immediately. A new `start_i` then runs a clean 25-pixel frame with 9 windows.
- Ignored start:
  - Stimulus: `start_i` during RUN and during DRAIN.
  - Required: no counter reset and no state change.
